// File: rtl/scm_port_arbiter.sv
// Request arbiter for a latch-based register file: one round-robin write per cycle,
// up to N_READ round-robin reads per cycle, read data returned one cycle after transfer.
module scm_port_arbiter #(
  parameter int unsigned N_REQ       = 8,
  parameter int unsigned N_READ      = 4,
  parameter int unsigned WADDR_WIDTH = 5,
  parameter int unsigned WDATA_WIDTH = 64,
  parameter int unsigned RDATA_WIDTH = 32,
  parameter int unsigned RADDR_WIDTH = WADDR_WIDTH + $clog2(WDATA_WIDTH / RDATA_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      rd_valid_i,
  input  logic [N_REQ-1:0][RADDR_WIDTH-1:0]     rd_addr_i,
  output logic [N_REQ-1:0]                      rd_ready_o,
  output logic [N_REQ-1:0]                      rsp_valid_o,
  output logic [N_REQ-1:0][RDATA_WIDTH-1:0]     rsp_data_o,
  input  logic [N_REQ-1:0]                      wr_valid_i,
  input  logic [N_REQ-1:0][WADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [N_REQ-1:0][WDATA_WIDTH-1:0]     wr_data_i,
  output logic [N_REQ-1:0]                      wr_ready_o,
  output logic [N_READ-1:0]                     mem_re_o,
  output logic [N_READ-1:0][RADDR_WIDTH-1:0]    mem_raddr_o,
  input  logic [N_READ-1:0][RDATA_WIDTH-1:0]    mem_rdata_i,
  output logic                                  mem_we_o,
  output logic [WADDR_WIDTH-1:0]                mem_waddr_o,
  output logic [WDATA_WIDTH-1:0]                mem_wdata_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SUB_W = RADDR_WIDTH - WADDR_WIDTH;

  logic [PTR_W-1:0]             wptr_q, wptr_d;
  logic [PTR_W-1:0]             rptr_q, rptr_d;
  logic [N_READ-1:0]            pv_q, pv_d;
  logic [N_READ-1:0][PTR_W-1:0] own_q, own_d;

  logic                         wgnt;
  logic [PTR_W-1:0]             widx;
  logic [N_REQ-1:0]             haz;

  function automatic logic [PTR_W-1:0] rot(input logic [PTR_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N_REQ;
    return PTR_W'(s);
  endfunction

  // Write arbitration: first valid writer at or after wptr wins.
  always_comb begin
    wr_ready_o  = '0;
    wgnt        = 1'b0;
    widx        = '0;
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!wgnt && wr_valid_i[rot(wptr_q, i)]) begin
          wgnt = 1'b1;
          widx = rot(wptr_q, i);
        end
      end
    end
    if (wgnt) begin
      wr_ready_o[widx] = 1'b1;
      mem_we_o         = 1'b1;
      mem_waddr_o      = wr_addr_i[widx];
      mem_wdata_o      = wr_data_i[widx];
    end
    wptr_d = wgnt ? rot(widx, 1) : wptr_q;
  end

  // A read of either half of the word being written this cycle must wait a cycle.
  always_comb begin
    haz = '0;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      haz[r] = wgnt && (rd_addr_i[r][RADDR_WIDTH-1:SUB_W] == wr_addr_i[widx]);
    end
  end

  // Read arbitration: k-th eligible requester from rptr is placed on port k.
  always_comb begin
    int unsigned      cnt;
    logic [PTR_W-1:0] r;
    logic [PTR_W-1:0] last;
    logic             any;
    cnt         = 0;
    r           = '0;
    last        = rptr_q;
    any         = 1'b0;
    rd_ready_o  = '0;
    mem_re_o    = '0;
    mem_raddr_o = '0;
    own_d       = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        r = rot(rptr_q, i);
        if (rd_valid_i[r] && !haz[r] && (cnt < N_READ)) begin
          rd_ready_o[r] = 1'b1;
          for (int unsigned k = 0; k < N_READ; k++) begin
            if (k == cnt) begin
              mem_re_o[k]    = 1'b1;
              mem_raddr_o[k] = rd_addr_i[r];
              own_d[k]       = r;
            end
          end
          cnt  = cnt + 1;
          last = r;
          any  = 1'b1;
        end
      end
    end
    pv_d   = mem_re_o;
    rptr_d = any ? rot(last, 1) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      pv_q   <= '0;
      own_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pv_q   <= pv_d;
      own_q  <= own_d;
    end
  end

  // Responses are suppressed while rst is high so in-flight reads are dropped.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < N_READ; k++) begin
        if (pv_q[k]) begin
          rsp_valid_o[own_q[k]] = 1'b1;
          rsp_data_o[own_q[k]]  = mem_rdata_i[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Randomized and directed bench for scm_port_arbiter with a queue-based response scoreboard.
module tb_scm_port_arbiter;
  localparam int N  = 8;
  localparam int NR = 4;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         rd_valid_i;
  logic [N-1:0][5:0]    rd_addr_i;
  logic [N-1:0]         rd_ready_o;
  logic [N-1:0]         rsp_valid_o;
  logic [N-1:0][31:0]   rsp_data_o;
  logic [N-1:0]         wr_valid_i;
  logic [N-1:0][4:0]    wr_addr_i;
  logic [N-1:0][63:0]   wr_data_i;
  logic [N-1:0]         wr_ready_o;
  logic [NR-1:0]        mem_re_o;
  logic [NR-1:0][5:0]   mem_raddr_o;
  logic [NR-1:0][31:0]  mem_rdata_i;
  logic                 mem_we_o;
  logic [4:0]           mem_waddr_o;
  logic [63:0]          mem_wdata_o;

  scm_port_arbiter #(
    .N_REQ(N), .N_READ(NR), .WADDR_WIDTH(5), .WDATA_WIDTH(64), .RDATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] initval(input int w);
    return {8'h5A, 24'(w), 8'hC3, 24'(w * 7 + 1)};
  endfunction

  // Stand-in for the latch register file: write at the edge, read address registered.
  logic [63:0]       rf [32];
  logic [NR-1:0][5:0] raddr_q;
  logic              rf_init;
  always @(posedge clk) begin
    if (rf_init) begin
      for (int w = 0; w < 32; w++) rf[w] <= initval(w);
    end else if (mem_we_o) begin
      rf[mem_waddr_o] <= mem_wdata_o;
    end
    raddr_q <= mem_raddr_o;
  end
  always_comb begin
    for (int k = 0; k < NR; k++)
      mem_rdata_i[k] = raddr_q[k][0] ? rf[raddr_q[k][5:1]][63:32] : rf[raddr_q[k][5:1]][31:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          req;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  // Reference state: held requests, round-robin pointers and a word-level memory image.
  logic [N-1:0] prd_v;
  logic [5:0]   prd_a [N];
  logic [N-1:0] pwr_v;
  logic [4:0]   pwr_a [N];
  logic [63:0]  pwr_d [N];
  logic [63:0]  shadow [32];
  int           wpt, rpt;
  logic         mon_en;

  task automatic step(input logic rst_v);
    logic [N-1:0]        e_wr, e_rd;
    logic                e_we;
    logic [4:0]          e_wa;
    logic [63:0]         e_wd;
    logic [NR-1:0]       e_re;
    logic [NR-1:0][5:0]  e_ra;
    int                  win, n, last, r;
    @(posedge clk);
    #1;
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      rd_valid_i[i] = prd_v[i];
      rd_addr_i[i]  = prd_a[i];
      wr_valid_i[i] = pwr_v[i];
      wr_addr_i[i]  = pwr_a[i];
      wr_data_i[i]  = pwr_d[i];
    end
    #1;
    e_wr = '0; e_rd = '0; e_we = 1'b0; e_wa = '0; e_wd = '0; e_re = '0; e_ra = '0;
    win = -1; n = 0; last = -1;
    if (!rst_v) begin
      for (int i = 0; i < N; i++) begin
        r = (wpt + i) % N;
        if (win < 0 && pwr_v[r]) win = r;
      end
      if (win >= 0) begin
        e_wr[win] = 1'b1; e_we = 1'b1; e_wa = pwr_a[win]; e_wd = pwr_d[win];
      end
      for (int i = 0; i < N; i++) begin
        r = (rpt + i) % N;
        if (prd_v[r] && !(e_we && prd_a[r][5:1] == e_wa) && n < NR) begin
          e_rd[r] = 1'b1; e_re[n] = 1'b1; e_ra[n] = prd_a[r];
          q.push_back('{due: cyc + 1, req: r,
                        data: prd_a[r][0] ? shadow[prd_a[r][5:1]][63:32] : shadow[prd_a[r][5:1]][31:0]});
          n++; last = r;
        end
      end
    end
    chk("wr_ready", 64'(wr_ready_o), 64'(e_wr));
    chk("rd_ready", 64'(rd_ready_o), 64'(e_rd));
    chk("mem_we", 64'(mem_we_o), 64'(e_we));
    chk("mem_waddr", 64'(mem_waddr_o), 64'(e_wa));
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("mem_re", 64'(mem_re_o), 64'(e_re));
    chk("mem_raddr", 64'(mem_raddr_o), 64'(e_ra));
    if (win >= 0) begin
      shadow[e_wa] = e_wd;
      pwr_v[win]   = 1'b0;
      wpt          = (win + 1) % N;
    end
    prd_v = prd_v & ~e_rd;
    if (last >= 0) rpt = (last + 1) % N;
    if (rst_v) begin
      wpt = 0; rpt = 0;
      q.delete();
    end
  endtask

  // Monitor: every cycle, responses due now must appear; all other requesters stay idle.
  initial begin
    logic [N-1:0] emask;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        emask = '0;
        while (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          emask[e.req] = 1'b1;
          chk($sformatf("rsp_valid[%0d]", e.req), 64'(rsp_valid_o[e.req]), 64'd1);
          chk($sformatf("rsp_data[%0d]", e.req), 64'(rsp_data_o[e.req]), 64'(e.data));
        end
        for (int r = 0; r < N; r++) begin
          if (!emask[r]) chk($sformatf("rsp_idle[%0d]", r), {31'b0, rsp_valid_o[r], rsp_data_o[r]}, 64'd0);
        end
      end
    end
  end

  initial begin
    int order [4];
    mon_en = 1'b0;
    rst = 1'b1; rf_init = 1'b1;
    rd_valid_i = '0; rd_addr_i = '0; wr_valid_i = '0; wr_addr_i = '0; wr_data_i = '0;
    prd_v = '0; pwr_v = '0; wpt = 0; rpt = 0;
    for (int i = 0; i < N; i++) begin
      prd_a[i] = '0; pwr_a[i] = '0; pwr_d[i] = '0;
    end
    for (int w = 0; w < 32; w++) shadow[w] = initval(w);
    @(posedge clk);
    #1 rf_init = 1'b0;
    step(1'b1);
    step(1'b1);
    mon_en = 1'b1;

    // All eight read: two groups of four, pointer wraps to 0.
    for (int i = 0; i < N; i++) begin prd_v[i] = 1'b1; prd_a[i] = 6'(i * 3); end
    step(1'b0);
    chk("all8_first", 64'(rd_ready_o), 64'h0F);
    step(1'b0);
    chk("all8_second", 64'(rd_ready_o), 64'hF0);
    prd_v[0] = 1'b1; prd_a[0] = 6'd9; prd_v[7] = 1'b1; prd_a[7] = 6'd20;
    step(1'b0);
    chk("rptr_wrap_port0", 64'(mem_raddr_o[0]), 64'd9);

    // Same-word hazard: write wins, read follows and sees the new data.
    pwr_v[2] = 1'b1; pwr_a[2] = 5'd5; pwr_d[2] = 64'hAAAA_BBBB_CCCC_DDDD;
    prd_v[3] = 1'b1; prd_a[3] = 6'd10;
    step(1'b0);
    chk("haz_stall", 64'(rd_ready_o[3]), 64'd0);
    chk("haz_write", 64'(wr_ready_o[2]), 64'd1);
    step(1'b0);
    chk("haz_retry", 64'(rd_ready_o[3]), 64'd1);
    prd_v[3] = 1'b1; prd_a[3] = 6'd11;
    step(1'b0);
    chk("haz_lo_data", 64'(rsp_data_o[3]), 64'hCCCC_DDDD);
    step(1'b0);
    chk("haz_hi_data", 64'(rsp_data_o[3]), 64'hAAAA_BBBB);

    // Held writes from 1, 4, 6 after reset: grant order 1,4,6,1.
    step(1'b1);
    for (int i = 0; i < 4; i++) begin
      pwr_v = 8'b0101_0010;
      for (int j = 0; j < N; j++) begin pwr_a[j] = 5'(20 + j); pwr_d[j] = {$urandom, $urandom}; end
      step(1'b0);
      order[i] = (i == 2) ? 6 : (i == 1) ? 4 : 1;
      chk($sformatf("wr_rr_%0d", i), 64'(wr_ready_o), 64'(1) << order[i]);
    end
    pwr_v = '0;
    step(1'b0);

    // Different word: read and write both proceed.
    pwr_v[0] = 1'b1; pwr_a[0] = 5'd4; pwr_d[0] = 64'h1111_2222_3333_4444;
    prd_v[1] = 1'b1; prd_a[1] = 6'd7;
    step(1'b0);
    chk("nohaz_rd", 64'(rd_ready_o[1]), 64'd1);
    chk("nohaz_wr", 64'(wr_ready_o[0]), 64'd1);
    step(1'b0);

    // Reset right after four grants drops their responses and clears pointers.
    prd_v = '1;
    step(1'b0);
    step(1'b1);
    chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
    prd_v = '1;
    step(1'b0);
    chk("rst_rptr0", 64'(rd_ready_o), 64'h0F);
    step(1'b0);
    step(1'b0);

    // Single requester back-to-back reads all land on port 0.
    for (int i = 0; i < 3; i++) begin
      prd_v[5] = 1'b1; prd_a[5] = 6'(i);
      step(1'b0);
      chk($sformatf("b2b_rdy_%0d", i), 64'(rd_ready_o), 64'h20);
      chk($sformatf("b2b_re_%0d", i), 64'(mem_re_o), 64'h1);
    end
    step(1'b0);

    // Randomized traffic over a small address range to stress hazards.
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!prd_v[r] && ($urandom % 3 == 0)) begin
          prd_v[r] = 1'b1; prd_a[r] = 6'($urandom_range(0, 15));
        end
        if (!pwr_v[r] && ($urandom % 4 == 0)) begin
          pwr_v[r] = 1'b1; pwr_a[r] = 5'($urandom_range(0, 7)); pwr_d[r] = {$urandom, $urandom};
        end
      end
      step(($urandom % 100) == 0);
    end

    prd_v = '0; pwr_v = '0;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scm_port_arbiter.md
SCM_PORT_ARBITER -- requirements
Module: scm_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of requesters.
REQ-002 SHALL have parameter N_READ, default 4, number of register-file read ports.
REQ-003 SHALL have parameter WADDR_WIDTH, default 5, 64b-word address width.
REQ-004 SHALL have parameter WDATA_WIDTH, default 64; RDATA_WIDTH, default 32; RADDR_WIDTH = WADDR_WIDTH+$clog2(WDATA_WIDTH/RDATA_WIDTH).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports rd_valid_i  in  N_REQ, rd_addr_i  in  N_REQ x RADDR_WIDTH, rd_ready_o  out  N_REQ: per-requester read request handshake.
REQ-008 SHALL have ports rsp_valid_o  out  N_REQ, rsp_data_o  out  N_REQ x RDATA_WIDTH: read responses.
REQ-009 SHALL have ports wr_valid_i  in  N_REQ, wr_addr_i  in  N_REQ x WADDR_WIDTH, wr_data_i  in  N_REQ x WDATA_WIDTH, wr_ready_o  out  N_REQ: write request handshake.
REQ-010 SHALL have ports mem_re_o  out  N_READ, mem_raddr_o  out  N_READ x RADDR_WIDTH, mem_rdata_i  in  N_READ x RDATA_WIDTH: drive the latch register file read ports.
REQ-011 SHALL have ports mem_we_o  out  1, mem_waddr_o  out  WADDR_WIDTH, mem_wdata_o  out  WDATA_WIDTH: drive the register file write port.

Function
REQ-012 SHALL treat a request as transferred in a cycle where valid and ready are both 1; ready_o is combinational from valid_i, state and addresses; requester holds valid/addr/data stable until transfer.
REQ-013 SHALL grant at most one write per cycle, round-robin: scan from write pointer wptr upward modulo N_REQ, first wr_valid_i wins; wptr <= winner+1 mod N_REQ after a grant, unchanged otherwise.
REQ-014 SHALL drive mem_we_o/mem_waddr_o/mem_wdata_o combinationally from the granted write in the same cycle; mem_we_o=0 and addr/data 0 when no write is granted.
REQ-015 SHALL treat a read as hazardous when a write is granted in the same cycle and rd_addr_i[RADDR_WIDTH-1:1] equals that write address (either 32b half); hazardous reads get rd_ready_o=0 that cycle (write wins).
REQ-016 SHALL grant up to N_READ non-hazardous reads per cycle: scan from read pointer rptr upward modulo N_REQ, k-th eligible requester (k=0..N_READ-1) assigned to port k.
REQ-017 SHALL set rptr <= (last granted requester + 1) mod N_REQ after any read grant, unchanged if none.
REQ-018 SHALL assert mem_re_o[k]=1 with mem_raddr_o[k]=granted address for each used port; unused ports mem_re_o[k]=0, mem_raddr_o[k]=0.
REQ-019 SHALL register, per port, a valid bit and the owning requester index at each rising edge.
REQ-020 SHALL return data with latency exactly 1: read transferred in cycle t -> rsp_valid_o[r]=1 and rsp_data_o[r]=mem_rdata_i[port] in cycle t+1 only.
REQ-021 SHALL drive rsp_valid_o[r]=0 and rsp_data_o[r]=0 when requester r has no response that cycle.
REQ-022 SHALL allow one requester to have a read and a write granted in the same cycle if non-hazardous, and to issue a new read every cycle.
REQ-023 SHALL guarantee a read transferred in cycle t+1 or later returns data written by a write transferred in cycle t.
REQ-024 SHALL never assign two requesters to one port nor one requester to two ports in a cycle.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, clear wptr, rptr, all port valid bits and owner indices to 0.
REQ-026 SHALL, in the cycle after reset, drive rsp_valid_o=0, rsp_data_o=0; a read in flight when rst asserts produces no response.
REQ-027 SHALL drive all ready_o, mem_re_o and mem_we_o to 0 while rst=1.

Verification
REQ-028 SHALL cover: all 8 requesters read, rptr=0 -> requesters 0-3 granted on ports 0-3, responses next cycle; next cycle 4-7 granted, rptr returns to 0.
REQ-029 SHALL cover: req 2 writes word 5 = 0xAAAA_BBBB_CCCC_DDDD while req 3 reads addr 10 same cycle -> req 3 stalled; read granted next cycle returns 0xCCCC_DDDD; addr 11 returns 0xAAAA_BBBB.
REQ-030 SHALL cover: write requests from 1, 4, 6 held continuously -> grants in order 1,4,6,1 with wptr=0 start.
REQ-031 SHALL cover: read to addr 7 with write to word 4 same cycle -> no stall, both granted, response in t+1.
REQ-032 SHALL cover: rst asserted in cycle after 4 read grants -> no rsp_valid_o asserted, pointers 0 afterwards.
REQ-033 SHALL cover: single requester 5 reads addrs 0,1,2 back-to-back -> three grants in consecutive cycles, three responses on port 0 with 1-cycle latency.
